if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer: owns the program counter and instruction-memory chip enable,
//  advances PC by 4 per accepted instruction, and applies flush, branch redirect and stall.
//  Sits between the pipeline control unit / branch resolver and the instruction memory.
//  Feeds the IF/ID register through a one-entry skid buffer, so stalls never drop a returned instruction.
// PARAMETERS
//  RESET_PC   32'h00000000  PC value loaded on reset and first address fetched
//  INST_W     32            instruction data width
// PORTS
//  clk            in   1       system clock; all state updates on posedge
//  rst            in   1       reset, synchronous, active-high (`RSTENABLE)
//  stall          in   1       ID stage cannot accept an instruction this cycle
//  flush          in   1       exception/flush request; highest priority after rst
//  flush_pc       in   32      new PC on flush
//  branch_flag    in   1       taken branch/jump resolved in ID
//  branch_target  in   32      redirect PC on branch_flag
//  inst_ack       in   1       memory returns inst_rdata for the current pc this cycle
//  inst_rdata     in   INST_W  instruction read data
//  pc             out  32      instruction fetch address
//  ce             out  1       instruction memory chip enable (`CHIPENABLE/`CHIPDISABLE)
//  if_pc          out  32      PC of instruction presented to ID
//  if_inst        out  INST_W  instruction presented to ID
//  if_valid       out  1       if_pc/if_inst hold a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, ce=0, if_valid=0, if_pc=0, if_inst=0, buffer empty, state IDLE.
//  States: IDLE -> FETCH (first edge with rst=0; ce=1 from then on, fetch of RESET_PC issued).
//   FETCH: ce=1, request outstanding at pc.
//   HOLD : instruction captured while stalled sits in skid buffer; ce=0; pc holds the next address.
//  Per-edge priority: rst > flush > branch_flag > stall > inst_ack.
//  flush (any state except IDLE): pc<=flush_pc&~3, buffer cleared, if_valid<=0, state FETCH; ack that cycle discarded.
//  branch_flag: as flush but pc<=branch_target&~3; the ack in that cycle (wrong-path) discarded.
//  FETCH, !stall, inst_ack: if_pc<=pc, if_inst<=inst_rdata, if_valid<=1, pc<=pc+4.
//  FETCH, !stall, !inst_ack: if_valid<=0 (bubble), pc held.
//  FETCH, stall, inst_ack: inst to buffer, pc<=pc+4, state HOLD; if_* held.
//  FETCH, stall, !inst_ack: everything held.
//  HOLD, stall: everything held, ce=0, inst_ack ignored.
//  HOLD, !stall: buffer -> if_*, if_valid<=1, state FETCH (ce=1 next cycle at held pc).
//  Latency: instruction appears on if_* the edge after inst_ack; no instruction lost or duplicated.
//  PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 wraps to 32'h00000000; pc[1:0] always 0.
//  Reset mid-operation discards buffer and outstanding request; returns to IDLE.
// STRUCTURE
//  Shared macro.v: `RSTENABLE, `CHIPENABLE/`CHIPDISABLE, `INSTADDRBUS, state encodings
//  (IDLE/FETCH/HOLD), `ZEROWORD. Next-PC selection (flush/branch/+4/hold) is a natural
//  combinational sub-module: pc_next_sel. Skid buffer and FSM stay in this module.
// TESTING
//  Reset 3 cycles, then inst_ack=1 always -> ce=1 one edge after rst drops; pc 0,4,8,...; if_pc lags pc by one.
//  stall=1 for 3 cycles arriving with ack at pc=0x10 -> HOLD, ce=0, pc=0x14; on release if_pc=0x10 once, next 0x14.
//  branch_flag=1, target 0x100, ack same cycle -> ack dropped, if_valid=0, next fetch pc=0x100.
//  flush and branch_flag together (0x200 vs 0x100) while in HOLD -> pc=0x200, buffer empty, if_valid=0.
//  Start with RESET_PC=32'hFFFFFFF8, continuous ack -> pc FFFFFFF8, FFFFFFFC, 00000000.
//  rst asserted while in HOLD -> next edge ce=0, pc=RESET_PC, if_valid=0; resumes from RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared types and constants for the fetch-stage sequencer
package if_fetch_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Fetch addresses are word aligned; low two bits of any redirect are dropped.
    function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_pc_next_sel.sv
// rtl/if_fetch_ctrl_pc_next_sel.sv - next-PC selection: flush > branch > +4 > hold
module if_fetch_ctrl_pc_next_sel
    import if_fetch_ctrl_pkg::*;
(
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] flush_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   advance,
    input  logic [INST_ADDR_W-1:0] pc,
    output logic [INST_ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = align_pc(flush_pc);
        end else if (branch_flag) begin
            pc_next = align_pc(branch_target);
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch sequencer: PC, chip enable, one-entry skid buffer into IF/ID
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              inst_ack,
    input  logic [INST_W-1:0] inst_rdata,
    output logic [31:0]       pc,
    output logic              ce,
    output logic [31:0]       if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              ce_q, ce_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       buf_pc_q, buf_pc_d;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;

    logic              active;
    logic              redirect;
    logic              advance;
    logic [31:0]       pc_next;

    // Redirects are ignored in IDLE; the first fetch is always RESET_PC.
    assign active   = (state_q != ST_IDLE);
    assign redirect = active && (flush || branch_flag);
    assign advance  = (state_q == ST_FETCH) && inst_ack;

    if_fetch_ctrl_pc_next_sel u_pc_next_sel (
        .flush         (active && flush),
        .flush_pc      (flush_pc),
        .branch_flag   (active && branch_flag),
        .branch_target (branch_target),
        .advance       (advance),
        .pc            (pc_q),
        .pc_next       (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_next;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        if (!active) begin
            state_d = ST_FETCH;
        end else if (redirect) begin
            state_d    = ST_FETCH;
            if_valid_d = 1'b0;
        end else if (state_q == ST_FETCH) begin
            if (!stall) begin
                if_valid_d = inst_ack;
                if (inst_ack) begin
                    if_pc_d   = pc_q;
                    if_inst_d = inst_rdata;
                end
            end else if (inst_ack) begin
                buf_pc_d   = pc_q;
                buf_inst_d = inst_rdata;
                state_d    = ST_HOLD;
            end
        end else if (!stall) begin
            if_pc_d    = buf_pc_q;
            if_inst_d  = buf_inst_q;
            if_valid_d = 1'b1;
            state_d    = ST_FETCH;
        end

        ce_d = (state_d == ST_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ce_q       <= CHIP_DISABLE;
            if_pc_q    <= ZERO_WORD;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            buf_pc_q   <= ZERO_WORD;
            buf_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign pc       = pc_q;
    assign ce       = ce_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule
